draw_polygon_layers: RTL and testbench
======================================

Name: draw_polygon_layers

Overview:
- Multi-polygon rasteriser for the world-space renderer: up to NUM_POLYS polygons, each with its own colour, drawn with fixed priority (index 0 on top).
- Per-pixel fixed-latency pipeline: pixel to world conversion, edge crossing test per polygon, then a priority pick.
- Polygon and camera state are double-buffered. New geometry is committed with a handshake and takes effect only at a frame boundary, so no frame shows a partial update.

Parameters:
PIXEL_WIDTH, 1280, active pixels per line
PIXEL_HEIGHT, 720, active lines per frame
WORLD_BITS, 32, signed world coordinate width
SCALE_LEVEL, 0, world units per pixel = 2**SCALE_LEVEL
MAX_NUM_VERTICES, 16, vertex slots per polygon
NUM_POLYS, 4, number of polygon channels

Ports:
clk_in  input  1  pixel clock
rst_n_in  input  1  asynchronous active-low reset
hcount_in  input  $clog2(PIXEL_WIDTH)  current pixel column
vcount_in  input  $clog2(PIXEL_HEIGHT)  current pixel row
camera_x_in  input  WORLD_BITS signed  camera centre x (staged)
camera_y_in  input  WORLD_BITS signed  camera centre y (staged)
xs_in  input  [NUM_POLYS][MAX_NUM_VERTICES] x WORLD_BITS signed  vertex x, in order
ys_in  input  [NUM_POLYS][MAX_NUM_VERTICES] x WORLD_BITS signed  vertex y, in order
num_points_in  input  [NUM_POLYS] x $clog2(MAX_NUM_VERTICES+1)  vertex count per polygon
colors_in  input  [NUM_POLYS] x 4  fill colour per polygon
commit_in  input  1  one-cycle pulse: staged inputs are ready to apply
commit_ack_out  output  1  one-cycle pulse: commit applied
pixel_color_out  output  4  colour of the topmost covering polygon
poly_id_out  output  $clog2(NUM_POLYS)  index of the winning polygon
valid_out  output  1  some enabled polygon covers the pixel

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0
  - shadow num_points = 0 (every polygon disabled)
  - shadow camera = 0
  - pending = 0
  - pipeline valid bits = 0
- Commit and frame latch:
  - commit_in sets pending.
  - A frame start is a cycle with hcount_in==0 and vcount_in==0. At a frame start with pending=1, all staged inputs are copied into the shadow registers, pending clears, and commit_ack_out pulses in the next cycle.
  - commit_in in the same cycle as a frame start that applies a commit is applied at that frame start; pending stays 0.
  - Repeated commits before a frame start merge into one ack.
  - The pipeline uses only shadow state.
- Pipeline (latency 5; the result for the pixel presented at cycle t appears at cycle t+5, one pixel per cycle, no stalls):
  - S0: wx = cam_x + ((hcount - PIXEL_WIDTH/2) <<< SCALE_LEVEL), wy = cam_y - ((vcount - PIXEL_HEIGHT/2) <<< SCALE_LEVEL). Wraps modulo 2**WORLD_BITS.
  - S1: for each polygon p and edge i < n_p, with j = (i+1 == n_p) ? 0 : i+1, register:
    - dx = xj - xi, dy = yj - yi, px = wx - xi, py = wy - yi, each WORLD_BITS+1 bits
    - up = (yi <= wy < yj), down = (yj <= wy < yi)
  - S2: cross = dx*py - px*dy, signed 2*WORLD_BITS+3 bits, no overflow.
  - S3: edge hit = (up & cross > 0) | (down & cross < 0). Hits are masked to i < n_p. inside_p = XOR of all hits. A polygon with n_p < 3 or n_p > MAX_NUM_VERTICES is never inside.
  - S4: lowest p with inside_p wins and drives pixel_color_out = colour_p, poly_id_out = p, valid_out = 1. If no polygon is inside, all three outputs are 0.
- Edge rules:
  - Horizontal edges never count.
  - A vertex is shared by half-open intervals, so there is no double count.
  - Pixels on left/bottom edges are inside; pixels on right/top edges are outside.
- Reset mid-frame clears the pipeline and shadow state; output is 0 until the next commit is latched.

Test Plan:
- Reset, no commit -> valid_out=0, colours 0, commit_ack_out never pulses over a full frame.
- Polygon 0 = square (-10,-10),(10,-10),(10,10),(-10,10), n=4, colour 4'h3, camera (0,0), SCALE 0; commit, then run a frame -> ack one cycle after the frame start. Pixel (640,360) gives colour 3, id 0, valid 1 at t+5. Pixel (660,360) (wx=20) gives valid 0.
- Polygon 0 as above plus polygon 1 = triangle (0,0),(40,0),(0,40), colour 4'hE -> at world (5,5) id 0, colour 3; at world (15,5) id 1, colour E; at world (50,50) valid 0.
- Concave L-shape with n=6 in a MAX_NUM_VERTICES=16 channel; stale data in slots 6..15 -> the notch pixel is outside; slots ≥6 are ignored.
- Staged square changed mid-frame with commit at row 100 -> that frame still renders the old shape; the change and the ack appear only at the next frame start. Two commits in one frame give exactly one ack.
- n=2 or n=0 with colour 4'h7 -> never valid. Camera (1000,-500) with SCALE_LEVEL=1: pixel (0,0) maps to world (-280,220).

Source files
------------

// File: rtl/draw_polygon_layers.sv
// Multi-polygon rasteriser: pixel -> world conversion, per-edge crossing test, priority pick.
// Camera and geometry are double-buffered and only swap at a frame start.
module draw_polygon_layers #(
  parameter int PIXEL_WIDTH      = 1280,
  parameter int PIXEL_HEIGHT     = 720,
  parameter int WORLD_BITS       = 32,
  parameter int SCALE_LEVEL      = 0,
  parameter int MAX_NUM_VERTICES = 16,
  parameter int NUM_POLYS        = 4
) (
  input  logic                                                     clk_in,
  input  logic                                                     rst_n_in,
  input  logic [$clog2(PIXEL_WIDTH)-1:0]                           hcount_in,
  input  logic [$clog2(PIXEL_HEIGHT)-1:0]                          vcount_in,
  input  logic signed [WORLD_BITS-1:0]                             camera_x_in,
  input  logic signed [WORLD_BITS-1:0]                             camera_y_in,
  input  logic [NUM_POLYS-1:0][MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] xs_in,
  input  logic [NUM_POLYS-1:0][MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] ys_in,
  input  logic [NUM_POLYS-1:0][$clog2(MAX_NUM_VERTICES+1)-1:0]     num_points_in,
  input  logic [NUM_POLYS-1:0][3:0]                                colors_in,
  input  logic                                                     commit_in,
  output logic                                                     commit_ack_out,
  output logic [3:0]                                               pixel_color_out,
  output logic [$clog2(NUM_POLYS)-1:0]                             poly_id_out,
  output logic                                                     valid_out
);
  localparam int W   = WORLD_BITS;
  localparam int E   = WORLD_BITS + 1;
  localparam int CW  = 2 * WORLD_BITS + 3;
  localparam int NV  = MAX_NUM_VERTICES;
  localparam int NP  = NUM_POLYS;
  localparam int NPW = $clog2(MAX_NUM_VERTICES + 1);
  localparam int IDW = $clog2(NUM_POLYS);

  logic signed [W-1:0]          cam_x_q, cam_y_q;
  logic [NP-1:0][NV-1:0][W-1:0] xs_q, ys_q;
  logic [NP-1:0][NPW-1:0]       np_q;
  logic [NP-1:0][3:0]           col_q;
  logic                         pending_q, pending_d, ack_q;
  logic                         frame_start, latch;

  assign frame_start = (hcount_in == '0) && (vcount_in == '0);
  assign latch       = frame_start && (pending_q || commit_in);
  assign pending_d   = latch ? 1'b0 : (pending_q || commit_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cam_x_q   <= '0;
      cam_y_q   <= '0;
      xs_q      <= '0;
      ys_q      <= '0;
      np_q      <= '0;
      col_q     <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ack_q     <= latch;
      if (latch) begin
        cam_x_q <= camera_x_in;
        cam_y_q <= camera_y_in;
        xs_q    <= xs_in;
        ys_q    <= ys_in;
        np_q    <= num_points_in;
        col_q   <= colors_in;
      end
    end
  end

  assign commit_ack_out = ack_q;

  logic signed [W-1:0] cam_x_eff, cam_y_eff, hoff, voff, wx_d, wy_d, wx_q, wy_q;
  logic [2:0]          vld_q;

  // The pixel at a committing frame start already belongs to the new frame, so it sees the new camera.
  assign cam_x_eff = latch ? camera_x_in : cam_x_q;
  assign cam_y_eff = latch ? camera_y_in : cam_y_q;
  assign hoff      = W'(hcount_in) - W'(PIXEL_WIDTH / 2);
  assign voff      = W'(vcount_in) - W'(PIXEL_HEIGHT / 2);
  assign wx_d      = cam_x_eff + (hoff <<< SCALE_LEVEL);
  assign wy_d      = cam_y_eff - (voff <<< SCALE_LEVEL);

  logic [NP-1:0][NV-1:0][E-1:0] dx_d, dy_d, px_d, py_d, dx_q, dy_q, px_q, py_q;
  logic [NP-1:0][NV-1:0]        up_d, dn_d, up_q, dn_q, up2_q, dn2_q;
  logic signed [W-1:0]          xi, yi, xj, yj;
  logic                         last, edge_en, poly_ok;

  always_comb begin
    dx_d    = '0;
    dy_d    = '0;
    px_d    = '0;
    py_d    = '0;
    up_d    = '0;
    dn_d    = '0;
    xi      = '0;
    yi      = '0;
    xj      = '0;
    yj      = '0;
    last    = 1'b0;
    edge_en = 1'b0;
    poly_ok = 1'b0;
    for (int p = 0; p < NP; p++) begin
      poly_ok = (np_q[p] >= NPW'(3)) && (np_q[p] <= NPW'(NV));
      for (int i = 0; i < NV; i++) begin
        last    = (NPW'(i + 1) == np_q[p]);
        xi      = xs_q[p][i];
        yi      = ys_q[p][i];
        xj      = last ? xs_q[p][0] : xs_q[p][(i + 1) % NV];
        yj      = last ? ys_q[p][0] : ys_q[p][(i + 1) % NV];
        edge_en = poly_ok && (NPW'(i) < np_q[p]);
        dx_d[p][i] = {xj[W-1], xj} - {xi[W-1], xi};
        dy_d[p][i] = {yj[W-1], yj} - {yi[W-1], yi};
        px_d[p][i] = {wx_q[W-1], wx_q} - {xi[W-1], xi};
        py_d[p][i] = {wy_q[W-1], wy_q} - {yi[W-1], yi};
        // Half-open y ranges share each vertex between its two edges and drop horizontal edges.
        up_d[p][i] = edge_en && (yi <= wy_q) && (wy_q < yj);
        dn_d[p][i] = edge_en && (yj <= wy_q) && (wy_q < yi);
      end
    end
  end

  logic [NP-1:0][NV-1:0][CW-1:0] cross_d, cross_q;

  always_comb begin
    cross_d = '0;
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < NV; i++) begin
        cross_d[p][i] = CW'($signed(dx_q[p][i])) * CW'($signed(py_q[p][i]))
                      - CW'($signed(px_q[p][i])) * CW'($signed(dy_q[p][i]));
      end
    end
  end

  logic [NP-1:0] inside_d, inside_q;
  logic          c_pos, c_neg;

  always_comb begin
    inside_d = '0;
    c_pos    = 1'b0;
    c_neg    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      for (int i = 0; i < NV; i++) begin
        c_neg       = cross_q[p][i][CW-1];
        c_pos       = !cross_q[p][i][CW-1] && (|cross_q[p][i]);
        inside_d[p] = inside_d[p] ^ ((up2_q[p][i] && c_pos) || (dn2_q[p][i] && c_neg));
      end
    end
    if (!vld_q[2]) inside_d = '0;
  end

  logic [NP-1:0][3:0] col1_q, col2_q, col3_q;
  logic               sel_valid;
  logic [IDW-1:0]     sel_id;
  logic [3:0]         sel_col;

  always_comb begin
    sel_valid = 1'b0;
    sel_id    = '0;
    sel_col   = '0;
    for (int p = NP - 1; p >= 0; p--) begin
      if (inside_q[p]) begin
        sel_valid = 1'b1;
        sel_id    = IDW'(p);
        sel_col   = col3_q[p];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_q           <= '0;
      wx_q            <= '0;
      wy_q            <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      px_q            <= '0;
      py_q            <= '0;
      up_q            <= '0;
      dn_q            <= '0;
      col1_q          <= '0;
      cross_q         <= '0;
      up2_q           <= '0;
      dn2_q           <= '0;
      col2_q          <= '0;
      inside_q        <= '0;
      col3_q          <= '0;
      valid_out       <= 1'b0;
      poly_id_out     <= '0;
      pixel_color_out <= '0;
    end else begin
      vld_q           <= {vld_q[1:0], 1'b1};
      wx_q            <= wx_d;
      wy_q            <= wy_d;
      dx_q            <= dx_d;
      dy_q            <= dy_d;
      px_q            <= px_d;
      py_q            <= py_d;
      up_q            <= up_d;
      dn_q            <= dn_d;
      col1_q          <= col_q;
      cross_q         <= cross_d;
      up2_q           <= up_q;
      dn2_q           <= dn_q;
      col2_q          <= col1_q;
      inside_q        <= inside_d;
      col3_q          <= col2_q;
      valid_out       <= sel_valid;
      poly_id_out     <= sel_id;
      pixel_color_out <= sel_col;
    end
  end

endmodule

// File: tb/tb_draw_polygon_layers.sv
// Bench for draw_polygon_layers: directed scenarios plus randomized geometry, checked against
// a ray-crossing reference model with frame-boundary commit semantics.
module tb_draw_polygon_layers;
  localparam int NP = 4;
  localparam int NV = 16;
  localparam int W  = 32;

  typedef struct packed {
    logic       v;
    logic [3:0] c;
    logic [1:0] id;
  } res_t;

  logic                         clk    = 1'b0;
  logic                         rst_n  = 1'b1;
  logic [10:0]                  hcount = '0;
  logic [9:0]                   vcount = '0;
  logic signed [W-1:0]          cam_x  = '0;
  logic signed [W-1:0]          cam_y  = '0;
  logic [NP-1:0][NV-1:0][W-1:0] xs     = '0;
  logic [NP-1:0][NV-1:0][W-1:0] ys     = '0;
  logic [NP-1:0][4:0]           nps    = '0;
  logic [NP-1:0][3:0]           cols   = '0;
  logic                         commit = 1'b0;
  logic                         ack0, ack1, valid0, valid1;
  logic [3:0]                   col0, col1;
  logic [1:0]                   id0, id1;

  int       n_checks = 0;
  int       n_errs   = 0;
  int       ack_seen = 0;
  int       m_xs [NP][NV];
  int       m_ys [NP][NV];
  int       m_n  [NP];
  logic [3:0] m_col [NP];
  int       m_cx = 0, m_cy = 0;
  bit       m_pend = 0, m_ack = 0;
  res_t     q0 [$];
  res_t     q1 [$];

  always #5 clk = ~clk;

  draw_polygon_layers #(.SCALE_LEVEL(0)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .camera_x_in(cam_x), .camera_y_in(cam_y), .xs_in(xs), .ys_in(ys),
    .num_points_in(nps), .colors_in(cols), .commit_in(commit),
    .commit_ack_out(ack0), .pixel_color_out(col0), .poly_id_out(id0), .valid_out(valid0));

  draw_polygon_layers #(.SCALE_LEVEL(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .camera_x_in(cam_x), .camera_y_in(cam_y), .xs_in(xs), .ys_in(ys),
    .num_points_in(nps), .colors_in(cols), .commit_in(commit),
    .commit_ack_out(ack1), .pixel_color_out(col1), .poly_id_out(id1), .valid_out(valid1));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Even-odd rule: count edges whose crossing with the horizontal line through the point lies strictly to its right.
  function automatic bit in_poly(int p, int wx, int wy);
    bit ins = 0;
    int n = m_n[p];
    if (n < 3 || n > NV) return 0;
    for (int i = 0; i < n; i++) begin
      int j = (i + 1) % n;
      longint x1 = m_xs[p][i];
      longint y1 = m_ys[p][i];
      longint x2 = m_xs[p][j];
      longint y2 = m_ys[p][j];
      if ((y1 <= wy && wy < y2) || (y2 <= wy && wy < y1)) begin
        longint den = y2 - y1;
        longint num = (x1 - wx) * den + (wy - y1) * (x2 - x1);
        if ((den > 0 && num > 0) || (den < 0 && num < 0)) ins = !ins;
      end
    end
    return ins;
  endfunction

  function automatic res_t model_pixel(int h, int v, int scale);
    res_t r = '0;
    bit found = 0;
    int wx = m_cx + (h - 640) * (1 << scale);
    int wy = m_cy - (v - 360) * (1 << scale);
    for (int p = 0; p < NP; p++) begin
      if (!found && in_poly(p, wx, wy)) begin
        found = 1;
        r.v   = 1'b1;
        r.c   = m_col[p];
        r.id  = 2'(p);
      end
    end
    return r;
  endfunction

  task automatic model_latch();
    for (int p = 0; p < NP; p++) begin
      m_n[p]   = int'(nps[p]);
      m_col[p] = cols[p];
      for (int i = 0; i < NV; i++) begin
        m_xs[p][i] = $signed(xs[p][i]);
        m_ys[p][i] = $signed(ys[p][i]);
      end
    end
    m_cx = cam_x;
    m_cy = cam_y;
  endtask

  task automatic step(input int h, input int v, input bit c);
    res_t r;
    hcount = 11'(h);
    vcount = 10'(v);
    commit = c;
    if (h == 0 && v == 0 && (m_pend || c)) begin
      model_latch();
      m_ack  = 1;
      m_pend = 0;
    end else begin
      m_ack = 0;
      if (c) m_pend = 1;
    end
    q0.push_back(model_pixel(h, v, 0));
    q1.push_back(model_pixel(h, v, 1));
    @(posedge clk);
    #1;
    commit = 1'b0;
    check_eq("ack0", ack0, m_ack);
    check_eq("ack1", ack1, m_ack);
    if (ack0) ack_seen++;
    if (q0.size() == 5) begin
      r = q0.pop_front();
      check_eq("pix0_valid", valid0, r.v);
      check_eq("pix0_color", col0, r.c);
      check_eq("pix0_id", id0, r.id);
      r = q1.pop_front();
      check_eq("pix1_valid", valid1, r.v);
      check_eq("pix1_color", col1, r.c);
      check_eq("pix1_id", id1, r.id);
    end
  endtask

  task automatic probe(input string tag, input int h, input int v, input bit ev,
                       input logic [3:0] ec, input logic [1:0] eid);
    step(h, v, 0);
    repeat (4) step(1, 1, 0);
    check_eq({tag, "_valid"}, valid0, ev);
    check_eq({tag, "_color"}, col0, ec);
    check_eq({tag, "_id"}, id0, eid);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    commit = 1'b0;
    m_pend = 0;
    m_ack  = 0;
    m_cx   = 0;
    m_cy   = 0;
    for (int p = 0; p < NP; p++) begin
      m_n[p]   = 0;
      m_col[p] = '0;
      for (int i = 0; i < NV; i++) begin
        m_xs[p][i] = 0;
        m_ys[p][i] = 0;
      end
    end
    q0.delete();
    q1.delete();
    #1;
    check_eq("rst_valid", valid0, 0);
    check_eq("rst_color", col0, 0);
    check_eq("rst_id", id0, 0);
    check_eq("rst_ack", ack0, 0);
    check_eq("rst_valid1", valid1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_vtx(input int p, input int i, input int x, input int y);
    xs[p][i] = 32'(x);
    ys[p][i] = 32'(y);
  endtask

  task automatic set_rect(input int p, input int x0, input int y0, input int x1, input int y1,
                          input logic [3:0] c);
    set_vtx(p, 0, x0, y0);
    set_vtx(p, 1, x1, y0);
    set_vtx(p, 2, x1, y1);
    set_vtx(p, 3, x0, y1);
    nps[p]  = 5'd4;
    cols[p] = c;
  endtask

  initial begin
    #2;
    do_reset();

    ack_seen = 0;
    step(0, 0, 0);
    for (int k = 0; k < 40; k++) step(600 + k, 300 + k, 0);
    step(0, 0, 0);
    step(2, 2, 0);
    check_eq("no_ack_without_commit", ack_seen, 0);
    probe("empty_centre", 640, 360, 0, 4'h0, 2'd0);

    set_rect(0, -10, -10, 10, 10, 4'h3);
    step(100, 50, 1);
    probe("before_fs", 640, 360, 0, 4'h0, 2'd0);
    step(0, 0, 0);
    check_eq("ack_after_fs", ack0, 1);
    step(3, 0, 0);
    check_eq("ack_one_cycle", ack0, 0);
    probe("centre", 640, 360, 1, 4'h3, 2'd0);
    probe("wx20", 660, 360, 0, 4'h0, 2'd0);
    probe("left_edge", 630, 360, 1, 4'h3, 2'd0);
    probe("right_edge", 650, 360, 0, 4'h0, 2'd0);
    probe("bottom_edge", 640, 370, 1, 4'h3, 2'd0);
    probe("top_edge", 640, 350, 0, 4'h0, 2'd0);

    set_vtx(1, 0, 0, 0);
    set_vtx(1, 1, 40, 0);
    set_vtx(1, 2, 0, 40);
    nps[1]  = 5'd3;
    cols[1] = 4'hE;
    step(10, 10, 1);
    step(0, 0, 0);
    probe("w5_5", 645, 355, 1, 4'h3, 2'd0);
    probe("w15_5", 655, 355, 1, 4'hE, 2'd1);
    probe("w50_50", 690, 310, 0, 4'h0, 2'd0);

    set_vtx(2, 0, 100, 0);
    set_vtx(2, 1, 140, 0);
    set_vtx(2, 2, 140, 20);
    set_vtx(2, 3, 120, 20);
    set_vtx(2, 4, 120, 40);
    set_vtx(2, 5, 100, 40);
    for (int i = 6; i < NV; i++)
      set_vtx(2, i, int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
    nps[2]  = 5'd6;
    cols[2] = 4'h9;
    step(20, 20, 1);
    step(0, 0, 0);
    probe("l_notch", 770, 330, 0, 4'h0, 2'd0);
    probe("l_inner", 750, 350, 1, 4'h9, 2'd2);
    probe("l_foot", 770, 350, 1, 4'h9, 2'd2);

    step(0, 0, 0);
    ack_seen = 0;
    set_rect(0, -30, -30, 30, 30, 4'h3);
    step(5, 100, 1);
    probe("old_shape_kept", 620, 360, 0, 4'h0, 2'd0);
    step(9, 100, 1);
    probe("old_shape_kept2", 620, 360, 0, 4'h0, 2'd0);
    check_eq("no_ack_mid_frame", ack_seen, 0);
    step(0, 0, 0);
    check_eq("ack_at_next_fs", ack0, 1);
    probe("new_shape", 620, 360, 1, 4'h3, 2'd0);
    step(0, 0, 0);
    step(4, 4, 0);
    check_eq("one_ack_two_commits", ack_seen, 1);

    set_rect(0, -50, -50, 50, 50, 4'h7);
    nps[0] = 5'd2;
    set_rect(1, -50, -50, 50, 50, 4'h7);
    nps[1] = 5'd0;
    set_rect(2, -50, -50, 50, 50, 4'h7);
    nps[2] = 5'd17;
    set_rect(3, -50, -50, 50, 50, 4'h7);
    nps[3] = 5'd0;
    step(11, 11, 1);
    step(0, 0, 0);
    probe("degenerate_n", 640, 360, 0, 4'h0, 2'd0);

    cam_x = 1000;
    cam_y = -500;
    set_rect(0, -282, 218, -278, 222, 4'h5);
    nps[2] = 5'd0;
    step(12, 12, 1);
    step(0, 0, 0);
    step(5, 5, 0);
    step(0, 0, 0);
    repeat (4) step(1, 1, 0);
    check_eq("s1_px00_valid", valid1, 1);
    check_eq("s1_px00_color", col1, 4'h5);
    check_eq("s1_px00_id", id1, 0);
    check_eq("s0_px00_valid", valid0, 0);
    step(1, 0, 0);
    repeat (4) step(1, 1, 0);
    check_eq("s1_right_edge_valid", valid1, 0);

    do_reset();
    ack_seen = 0;
    step(0, 0, 0);
    repeat (4) step(1, 1, 0);
    check_eq("post_reset_s1_valid", valid1, 0);
    step(0, 0, 0);
    step(3, 3, 0);
    check_eq("post_reset_no_ack", ack_seen, 0);

    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < NP; p++) begin
        nps[p]  = 5'($urandom_range(0, 18));
        cols[p] = 4'($urandom);
        for (int i = 0; i < NV; i++)
          set_vtx(p, i, int'($urandom_range(0, 240)) - 120, int'($urandom_range(0, 240)) - 120);
      end
      cam_x = int'($urandom_range(0, 100)) - 50;
      cam_y = int'($urandom_range(0, 100)) - 50;
      step(540 + int'($urandom_range(0, 200)), 260 + int'($urandom_range(0, 200)), 1);
      step(0, 0, 0);
      for (int k = 0; k < 50; k++) begin
        int r = int'($urandom_range(0, 99));
        if (r < 5) step(0, 0, bit'($urandom_range(0, 1)));
        else step(540 + int'($urandom_range(0, 200)), 260 + int'($urandom_range(0, 200)), r < 10);
      end
      if (it == 30) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
